// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: serializes a 48-bit SD command token with on-the-fly CRC7, one bit per card-clock tick
module sd_cmd_tx #(
  parameter int NCC_BITS = 8
) (
  input  logic        ex_clk,
  input  logic        ex_resetn,
  input  logic        sd_clk_tick,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] arg,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        busy,
  output logic        done
);
  localparam int CW = (NCC_BITS > 64) ? $clog2(NCC_BITS) : 6;
  typedef enum logic [2:0] {S_IDLE, S_LOAD_WAIT, S_DATA, S_CRC, S_END, S_GAP} state_t;
  state_t        state;
  logic [39:0]   sr;
  logic [6:0]    crc;
  logic [CW-1:0] cnt;
  function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction
  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      state   <= S_IDLE;
      sr      <= '0;
      crc     <= '0;
      cnt     <= '0;
      cmd_out <= 1'b1;
      cmd_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          sr    <= {2'b01, cmd_index, arg};
          crc   <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= S_LOAD_WAIT;
        end
        S_LOAD_WAIT: if (sd_clk_tick) begin
          cmd_oe  <= 1'b1;
          cmd_out <= sr[39];
          crc     <= crc_step(crc, sr[39]);
          sr      <= {sr[38:0], 1'b0};
          cnt     <= CW'(1);
          state   <= S_DATA;
        end
        S_DATA: if (sd_clk_tick) begin
          if (cnt == CW'(40)) begin
            cmd_out <= crc[6];
            crc     <= {crc[5:0], 1'b0};
            cnt     <= CW'(1);
            state   <= S_CRC;
          end else begin
            cmd_out <= sr[39];
            crc     <= crc_step(crc, sr[39]);
            sr      <= {sr[38:0], 1'b0};
            cnt     <= cnt + CW'(1);
          end
        end
        S_CRC: if (sd_clk_tick) begin
          if (cnt == CW'(7)) begin
            cmd_out <= 1'b1;
            state   <= S_END;
          end else begin
            cmd_out <= crc[6];
            crc     <= {crc[5:0], 1'b0};
            cnt     <= cnt + CW'(1);
          end
        end
        S_END: if (sd_clk_tick) begin
          cmd_oe  <= 1'b0;
          cmd_out <= 1'b1;
          cnt     <= '0;
          if (NCC_BITS == 0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            state <= S_GAP;
          end
        end
        S_GAP: if (sd_clk_tick) begin
          if (cnt == CW'(NCC_BITS - 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_cmd_tx.sv
// tb_sd_cmd_tx: directed token checks for sd_cmd_tx with default and zero Ncc spacing
module tb_sd_cmd_tx;
  logic ex_clk = 1'b0, ex_resetn = 1'b0, tick = 1'b0, start_a = 1'b0, start_b = 1'b0;
  logic [5:0] cmd_index = '0;
  logic [31:0] arg = '0;
  logic out_a, oe_a, busy_a, done_a, out_b, oe_b, busy_b, done_b;
  logic o_out, o_oe, o_busy, o_done;
  logic sel = 1'b0, gate = 1'b0;
  int period = 4, cyc_n = 0, tick_n = 0, oe_n = 0, done_n = 0, done_at = 0;
  int n_chk = 0, n_pass = 0;
  logic [47:0] tok = '0;
  typedef struct {
    logic [5:0]  idx;
    logic [31:0] a;
    logic [47:0] tok;
  } vec_t;
  vec_t vt [3];
  assign o_out  = sel ? out_b  : out_a;
  assign o_oe   = sel ? oe_b   : oe_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  always #5 ex_clk = ~ex_clk;
  sd_cmd_tx #(.NCC_BITS(8)) dut_a (
    .ex_clk(ex_clk), .ex_resetn(ex_resetn), .sd_clk_tick(tick), .start(start_a),
    .cmd_index(cmd_index), .arg(arg), .cmd_out(out_a), .cmd_oe(oe_a), .busy(busy_a), .done(done_a)
  );
  sd_cmd_tx #(.NCC_BITS(0)) dut_b (
    .ex_clk(ex_clk), .ex_resetn(ex_resetn), .sd_clk_tick(tick), .start(start_b),
    .cmd_index(cmd_index), .arg(arg), .cmd_out(out_b), .cmd_oe(oe_b), .busy(busy_b), .done(done_b)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  // One clock: observe what the last edge produced, then schedule the next tick
  task automatic cyc();
    @(negedge ex_clk);
    if (tick) begin
      tick_n++;
      if (o_oe) begin
        tok = {tok[46:0], o_out};
        oe_n++;
      end
    end
    if (o_done) begin
      done_n++;
      done_at = tick_n;
    end
    cyc_n++;
    tick = !gate && (cyc_n % period == 0);
  endtask
  task automatic send(input logic [5:0] idx, input logic [31:0] a);
    cmd_index = idx;
    arg = a;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    start_b = 1'b0;
    tick_n = 0; oe_n = 0; done_n = 0; done_at = 0; tok = '0;
    check("busy_after_start", o_busy, 1);
  endtask
  task automatic run_ticks(input int n);
    for (int i = 0; i < 5000 && tick_n < n; i++) cyc();
  endtask
  task automatic wait_done();
    for (int i = 0; i < 5000 && done_n == 0; i++) cyc();
  endtask
  task automatic finish_frame(input string name, input logic [47:0] exp_tok, input int exp_at);
    wait_done();
    repeat (4 * period + 2) cyc();
    check({name, "_token"}, tok, exp_tok);
    check({name, "_oe_ticks"}, oe_n, 48);
    check({name, "_done_count"}, done_n, 1);
    check({name, "_done_tick"}, done_at, exp_at);
    check({name, "_busy_idle"}, o_busy, 0);
  endtask
  initial begin
    logic v_out, v_oe, held;
    int v_tick;
    vt[0] = '{6'd0,  32'h00000000, 48'h400000000095};
    vt[1] = '{6'd17, 32'h00000000, 48'h510000000055};
    vt[2] = '{6'd8,  32'h000001AA, 48'h48000001AA87};
    repeat (3) cyc();
    check("rst_cmd_out", out_a, 1);
    check("rst_cmd_oe", oe_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_b_cmd_oe", oe_b, 0);
    ex_resetn = 1'b1;
    repeat (2) cyc();
    for (int i = 0; i < 3; i++) begin
      send(vt[i].idx, vt[i].a);
      finish_frame($sformatf("vec%0d", i), vt[i].tok, 57);
    end
    send(6'd0, 32'h0);
    run_ticks(20);
    cmd_index = 6'd17;
    arg = 32'hDEADBEEF;
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    check("busy_mid_frame", o_busy, 1);
    run_ticks(52);
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    finish_frame("ignore_start", 48'h400000000095, 57);
    send(6'd8, 32'h000001AA);
    run_ticks(20);
    gate = 1'b1;
    cyc();
    v_out = o_out;
    v_oe = o_oe;
    v_tick = tick_n;
    held = 1'b1;
    repeat (100) begin
      cyc();
      held &= (o_out === v_out) && (o_oe === v_oe);
    end
    check("gate_hold", held, 1);
    check("gate_no_tick", tick_n, v_tick);
    check("gate_oe_driving", v_oe, 1);
    gate = 1'b0;
    finish_frame("gated", 48'h48000001AA87, 57);
    send(6'd0, 32'h0);
    run_ticks(43);
    #2 ex_resetn = 1'b0;
    #1;
    check("async_rst_oe", oe_a, 0);
    check("async_rst_out", out_a, 1);
    check("async_rst_busy", busy_a, 0);
    cyc();
    cyc();
    ex_resetn = 1'b1;
    cyc();
    send(6'd0, 32'h0);
    finish_frame("after_rst", 48'h400000000095, 57);
    sel = 1'b1;
    period = 1;
    cyc();
    send(6'd0, 32'h0);
    wait_done();
    check("ncc0_cmd0_token", tok, 48'h400000000095);
    check("ncc0_cmd0_done_tick", done_at, 49);
    check("ncc0_cmd0_oe_ticks", oe_n, 48);
    send(6'd55, 32'h0);
    wait_done();
    repeat (4) cyc();
    check("ncc0_cmd55_token", tok, 48'h770000000065);
    check("ncc0_cmd55_done_tick", done_at, 49);
    check("ncc0_cmd55_done_count", done_n, 1);
    check("ncc0_cmd55_busy_idle", o_busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
